// File: rtl/fetch_stage.sv
// fetch_stage: RV32I instruction-fetch front end with PC, instruction buffer and redirect handling.
// Ports:
//   clk, rst_n                  clock (rising edge), asynchronous active-low reset
//   imem_req, imem_addr         fetch request and address to the synchronous instruction memory
//   imem_rdata                  instruction word returned one cycle after the request
//   redirect_en, redirect_pc    PC change from execute (target low two bits ignored)
//   valid_d, ready_d            handshake towards decode
//   instr_d, pc_d, pcplus4_d    head-of-buffer instruction, its PC and PC+4 (zero when empty)
module fetch_stage #(
    parameter int ADDRESS_WIDTH = 32,
    parameter int DEPTH = 4,
    parameter logic [ADDRESS_WIDTH-1:0] RESET_PC = '0
) (
    input  logic                     clk,
    input  logic                     rst_n,
    output logic                     imem_req,
    output logic [ADDRESS_WIDTH-1:0] imem_addr,
    input  logic [ADDRESS_WIDTH-1:0] imem_rdata,
    input  logic                     redirect_en,
    input  logic [ADDRESS_WIDTH-1:0] redirect_pc,
    output logic                     valid_d,
    input  logic                     ready_d,
    output logic [ADDRESS_WIDTH-1:0] instr_d,
    output logic [ADDRESS_WIDTH-1:0] pc_d,
    output logic [ADDRESS_WIDTH-1:0] pcplus4_d
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);
    logic [ADDRESS_WIDTH-1:0] pc, inflight_pc;
    logic                     inflight;
    logic [PW-1:0]            rd_ptr, wr_ptr;
    logic [CW-1:0]            count;
    logic [CW:0]              used;
    logic [ADDRESS_WIDTH-1:0] instr_mem [DEPTH];
    logic [ADDRESS_WIDTH-1:0] pc_mem [DEPTH];
    logic                     push, pop;
    // Credit rule: buffered plus outstanding entries never exceed DEPTH, so a push always has room.
    assign used      = {1'b0, count} + {{CW{1'b0}}, inflight};
    assign imem_req  = rst_n && !redirect_en && (used < LIMIT);
    assign imem_addr = pc;
    // A response during a redirect cycle is wrong-path; inflight is cleared so the next one is dropped too.
    assign push      = inflight && !redirect_en;
    assign valid_d   = count != '0;
    assign pop       = valid_d && ready_d && !redirect_en;
    assign instr_d   = valid_d ? instr_mem[rd_ptr] : '0;
    assign pc_d      = valid_d ? pc_mem[rd_ptr] : '0;
    assign pcplus4_d = valid_d ? pc_mem[rd_ptr] + ADDRESS_WIDTH'(4) : '0;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc          <= RESET_PC;
            inflight    <= 1'b0;
            inflight_pc <= '0;
            rd_ptr      <= '0;
            wr_ptr      <= '0;
            count       <= '0;
        end else if (redirect_en) begin
            pc       <= {redirect_pc[ADDRESS_WIDTH-1:2], 2'b00};
            inflight <= 1'b0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            count    <= '0;
        end else begin
            inflight <= imem_req;
            if (imem_req) begin
                pc          <= pc + ADDRESS_WIDTH'(4);
                inflight_pc <= pc;
            end
            if (push) wr_ptr <= wr_ptr + PW'(1);
            if (pop) rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(push) - CW'(pop);
        end
    end
    always_ff @(posedge clk) begin
        if (push) begin
            instr_mem[wr_ptr] <= imem_rdata;
            pc_mem[wr_ptr]    <= inflight_pc;
        end
    end
endmodule

// File: tb/tb_fetch_stage.sv
// tb_fetch_stage: directed table-driven bench for fetch_stage (default and wrapping RESET_PC instances).
module tb_fetch_stage;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        redirect_en = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        ready_d = 1'b1;
    logic        imem_req, imem_req2, valid_d, valid_d2;
    logic [31:0] imem_addr, imem_addr2, imem_rdata, imem_rdata2;
    logic [31:0] instr_d, pc_d, pcplus4_d, instr_d2, pc_d2, pcplus4_d2;
    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    // Instruction memory model: word returned one cycle after the request is addr + 0x100.
    always @(posedge clk) begin
        imem_rdata  <= imem_req  ? imem_addr  + 32'h100 : 32'hDEAD_BEEF;
        imem_rdata2 <= imem_req2 ? imem_addr2 + 32'h100 : 32'hDEAD_BEEF;
    end

    fetch_stage dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_rdata(imem_rdata), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .valid_d(valid_d), .ready_d(ready_d), .instr_d(instr_d), .pc_d(pc_d),
        .pcplus4_d(pcplus4_d)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut2 (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req2), .imem_addr(imem_addr2),
        .imem_rdata(imem_rdata2), .redirect_en(redirect_en), .redirect_pc(redirect_pc),
        .valid_d(valid_d2), .ready_d(ready_d), .instr_d(instr_d2), .pc_d(pc_d2),
        .pcplus4_d(pcplus4_d2)
    );

    typedef struct {
        logic        ready;
        logic        rdr_en;
        logic [31:0] rdr_pc;
        logic        exp_req;
        logic [31:0] exp_addr;
        logic        exp_valid;
        logic [31:0] exp_pc;
    } vec_t;

    vec_t v [28];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic req, input logic [31:0] addr,
                           input logic vld, input logic [31:0] p, input logic [31:0] off,
                           input logic a_req, input logic [31:0] a_addr, input logic a_vld,
                           input logic [31:0] a_instr, input logic [31:0] a_pc,
                           input logic [31:0] a_p4);
        logic [31:0] ep;
        ep = p + off;
        chk({tag, " imem_req"}, {31'b0, a_req}, {31'b0, req});
        if (req) chk({tag, " imem_addr"}, a_addr, addr + off);
        chk({tag, " valid_d"}, {31'b0, a_vld}, {31'b0, vld});
        chk({tag, " pc_d"}, a_pc, vld ? ep : 32'h0);
        chk({tag, " instr_d"}, a_instr, vld ? ep + 32'h100 : 32'h0);
        chk({tag, " pcplus4_d"}, a_p4, vld ? ep + 32'h4 : 32'h0);
    endtask

    initial begin
        v[0]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h0,   1'b0, 32'h0};
        v[1]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h4,   1'b0, 32'h0};
        v[2]  = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h8,   1'b1, 32'h0};
        v[3]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'hC,   1'b1, 32'h4};
        v[4]  = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h10,  1'b1, 32'h4};
        v[5]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h14,  1'b1, 32'h4};
        v[6]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h14,  1'b1, 32'h4};
        v[7]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h14,  1'b1, 32'h4};
        v[8]  = '{1'b0, 1'b0, 32'h0,   1'b0, 32'h14,  1'b1, 32'h4};
        v[9]  = '{1'b1, 1'b0, 32'h0,   1'b0, 32'h14,  1'b1, 32'h4};
        v[10] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h14,  1'b1, 32'h8};
        v[11] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h18,  1'b1, 32'hC};
        v[12] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h1C,  1'b1, 32'h10};
        v[13] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h20,  1'b1, 32'h14};
        v[14] = '{1'b0, 1'b0, 32'h0,   1'b1, 32'h24,  1'b1, 32'h18};
        v[15] = '{1'b0, 1'b1, 32'h200, 1'b0, 32'h28,  1'b1, 32'h18};
        v[16] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0};
        v[17] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h0};
        v[18] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h200};
        v[19] = '{1'b1, 1'b1, 32'h203, 1'b0, 32'h20C, 1'b1, 32'h204};
        v[20] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h200, 1'b0, 32'h0};
        v[21] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h204, 1'b0, 32'h0};
        v[22] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h208, 1'b1, 32'h200};
        v[23] = '{1'b1, 1'b1, 32'h40,  1'b0, 32'h20C, 1'b1, 32'h204};
        v[24] = '{1'b1, 1'b1, 32'h80,  1'b0, 32'h40,  1'b0, 32'h0};
        v[25] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h80,  1'b0, 32'h0};
        v[26] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h84,  1'b0, 32'h0};
        v[27] = '{1'b1, 1'b0, 32'h0,   1'b1, 32'h88,  1'b1, 32'h80};

        repeat (3) @(negedge clk);
        #1;
        chk_out("reset", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,
                imem_req, imem_addr, valid_d, instr_d, pc_d, pcplus4_d);
        chk("reset imem_addr", imem_addr, 32'h0);
        chk("reset dut2 imem_addr", imem_addr2, 32'hFFFF_FFF8);

        // Until the first redirect the wrapping instance runs the same sequence offset by its RESET_PC.
        for (int i = 0; i < 28; i++) begin
            @(negedge clk);
            rst_n       = 1'b1;
            ready_d     = v[i].ready;
            redirect_en = v[i].rdr_en;
            redirect_pc = v[i].rdr_pc;
            #1;
            chk_out($sformatf("cyc%0d", i), v[i].exp_req, v[i].exp_addr, v[i].exp_valid,
                    v[i].exp_pc, 32'h0, imem_req, imem_addr, valid_d, instr_d, pc_d, pcplus4_d);
            chk_out($sformatf("cyc%0d dut2", i), v[i].exp_req, v[i].exp_addr, v[i].exp_valid,
                    v[i].exp_pc, i <= 15 ? 32'hFFFF_FFF8 : 32'h0,
                    imem_req2, imem_addr2, valid_d2, instr_d2, pc_d2, pcplus4_d2);
        end

        // Asynchronous reset in the middle of a stream clears the outputs without a clock edge.
        redirect_en = 1'b0;
        ready_d     = 1'b0;
        #2;
        rst_n = 1'b0;
        #1;
        chk_out("async_rst", 1'b0, 32'h0, 1'b0, 32'h0, 32'h0,
                imem_req, imem_addr, valid_d, instr_d, pc_d, pcplus4_d);
        chk("async_rst dut2 valid_d", {31'b0, valid_d2}, 32'h0);
        ready_d = 1'b1;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk_out("post_rst cyc0", 1'b1, 32'h0, 1'b0, 32'h0, 32'h0,
                imem_req, imem_addr, valid_d, instr_d, pc_d, pcplus4_d);
        @(negedge clk);
        #1;
        chk_out("post_rst cyc1", 1'b1, 32'h4, 1'b0, 32'h0, 32'h0,
                imem_req, imem_addr, valid_d, instr_d, pc_d, pcplus4_d);
        @(negedge clk);
        #1;
        chk_out("post_rst cyc2", 1'b1, 32'h8, 1'b1, 32'h0, 32'h0,
                imem_req, imem_addr, valid_d, instr_d, pc_d, pcplus4_d);
        chk_out("post_rst cyc2 dut2", 1'b1, 32'h8, 1'b1, 32'h0, 32'hFFFF_FFF8,
                imem_req2, imem_addr2, valid_d2, instr_d2, pc_d2, pcplus4_d2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
